serial_sub_ctrl: RTL and testbench

Bit-serial subtract controller for the ALU datapath. It accepts a WIDTH-bit subtraction request, then computes the result over WIDTH cycles. It uses a single shared 1-bit full-subtractor slice (diff = a^b^c, borrow = ~a&b | b&c | c&~a), one bit per cycle, LSB first. Operand shifting, borrow chaining, bit counting and the start/busy/done handshake are all sequenced here, so the ALU gets multi-bit subtraction at the cost of one subtractor cell.

---
 rtl/serial_sub_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_serial_sub_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
// ---------------
// Bit-serial subtract controller. A WIDTH-bit request (a - b - bin) is
// computed over WIDTH clock cycles, LSB first, by time-multiplexing a single
// 1-bit full-subtractor slice.
//
// Handshake: start is a request that is taken on a clock edge while the FSM
// is in IDLE, or in DONE (the DONE cycle doubles as an accept window so that
// a held start gives one operation every WIDTH+1 cycles). On the accepting
// edge a, b and bin are captured; busy is high for the WIDTH RUN cycles that
// follow. Operand inputs are not looked at again until the next accept. done
// is a one-cycle pulse that marks diff/borr (and ovf) as final. The results
// hold until the next accepted request shifts new bits in. start seen in RUN
// is dropped, never queued.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (aborts any operation)
//   start request
//   a     minuend, WIDTH bits
//   b     subtrahend, WIDTH bits
//   bin   borrow-in
//   busy  high while the FSM is in RUN
//   done  one-cycle result-valid pulse
//   diff  (a - b - bin) mod 2^WIDTH
//   borr  borrow-out of the MSB slice
//   ovf   signed overflow (only when SERIAL_SUB_OVF_EN is defined)
//
// Optional feature macro: SERIAL_SUB_OVF_EN adds the ovf port and its logic.

// One-bit full subtractor: d = x - y - c, bo = borrow out.
module serial_sub_slice (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ c;
  assign bo = (~x & y) | (y & c) | (c & ~x);
endmodule

module serial_sub_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borr
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             brw;
  logic             borr_r;
  logic [CW-1:0]    cnt;

  logic load;     // capture operands on this edge
  logic shift;    // process one bit on this edge
  logic last;     // the bit processed on this edge is the MSB

  logic slice_d;
  logic slice_bo;

  // The only subtractor cell in the design.
  serial_sub_slice u_slice (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .c  (brw),
    .d  (slice_d),
    .bo (slice_bo)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-edge controls
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        shift = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // Back-to-back: a held start is taken as the pulse ends.
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand shifters, borrow chain, bit counter, result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      brw     <= 1'b0;
      borr_r  <= 1'b0;
      cnt     <= '0;
    end else if (load) begin
      a_sr <= a;
      b_sr <= b;
      brw  <= bin;
      cnt  <= '0;
    end else if (shift) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      diff_sr <= {slice_d, diff_sr[WIDTH-1:1]};
      brw     <= slice_bo;
      cnt     <= cnt + 1'b1;
      if (last) begin
        borr_r <= slice_bo;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_r;

  // On the MSB edge a_sr[0]/b_sr[0] hold the operand sign bits; overflow
  // when the signs differ and the result sign differs from the minuend.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (shift && last) begin
      ovf_r <= (a_sr[0] ^ b_sr[0]) & (slice_d ^ a_sr[0]);
    end
  end

  assign ovf = ovf_r;
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign diff = diff_sr;
  assign borr = borr_r;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed testbench for serial_sub_ctrl (WIDTH=4). Valid/ready semantics:
// start is a request taken on the edge where the DUT is IDLE or DONE; done
// is a one-cycle pulse marking diff/borr final. Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_serial_sub_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borr;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .borr  (borr)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Single request: pulse start, check busy for W cycles, done pulse and
  // final result, then the return to idle with the result held.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tbin, input logic [W-1:0] ediff, input logic eborr);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    step();                           // accepting edge E0
    start = 1'b0;
    a = ~ta; b = ~tb;                 // operand changes while busy are ignored
    for (int i = 0; i < W; i++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      step();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
    chk({tag, "_diff"}, 32'(diff), 32'(ediff));
    chk({tag, "_borr"}, 32'(borr), 32'(eborr));
    step();
    chk({tag, "_done_lo"}, 32'(done), 32'd0);
    chk({tag, "_diff_hold"}, 32'(diff), 32'(ediff));
  endtask

  // Directed stimulus
  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borr", 32'(borr), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif

    run_op("basic_9m3", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0);
    run_op("under_3m9", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1);
    run_op("bin_0m0", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1);
    run_op("eq_5m5", 4'd5, 4'd5, 1'b0, 4'd0, 1'b0);
    run_op("bin_7m2", 4'd7, 4'd2, 1'b1, 4'd4, 1'b0);

    // Back-to-back with start held high
    a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
    step();                           // E0
    a = 4'd2; b = 4'd1;               // presented during busy
    for (int i = 0; i < W; i++) begin
      chk("b2b_busy1", 32'(busy), 32'd1);
      step();
    end
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_diff1", 32'(diff), 32'd6);
    step();                           // second accept on the edge after done
    start = 1'b0;
    chk("b2b_reaccept", 32'(busy), 32'd1);
    chk("b2b_done1_lo", 32'(done), 32'd0);
    for (int i = 0; i < W - 1; i++) begin
      step();
      chk("b2b_wait", 32'(done), 32'd0);
    end
    step();                           // 5 cycles after first done
    chk("b2b_done2", 32'(done), 32'd1);
    chk("b2b_diff2", 32'(diff), 32'd1);
    chk("b2b_borr2", 32'(borr), 32'd0);
    step();
    chk("b2b_idle", 32'(busy), 32'd0);

    // Reset abort during the 2nd RUN cycle
    a = 4'd6; b = 4'd1; bin = 1'b0; start = 1'b1;
    step();                           // E0
    start = 1'b0;
    step();                           // E1: now in 2nd RUN cycle
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borr", 32'(borr), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      step();
      chk("abort_nodone", 32'(done), 32'd0);
    end
    run_op("post_8m1", 4'd8, 4'd1, 1'b0, 4'd7, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
    run_op("ovf_7mF", 4'd7, 4'hF, 1'b0, 4'd8, 1'b1);
    chk("ovf_set", 32'(ovf), 32'd1);
    run_op("ovf_7m1", 4'd7, 4'd1, 1'b0, 4'd6, 1'b0);
    chk("ovf_clr", 32'(ovf), 32'd0);
`endif

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
